// File: rtl/stopwatch_key_ctrl_pkg.sv
// Shared constants for the stopwatch key controller.
//   DEBOUNCE_TIME_DEFAULT : stable-sample count for a 20 ms window at 50 MHz
//   CNT_W                 : width of each key's stability counter
//   key_state_t           : debounce FSM state encoding
//   is_held()             : debounced "key held" level for a given FSM state
package stopwatch_key_ctrl_pkg;

  localparam int unsigned DEBOUNCE_TIME_DEFAULT = 1000000;
  localparam int unsigned CNT_W = 20;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  // While a release is still being qualified the key still counts as held.
  function automatic logic is_held(input key_state_t s);
    return (s == PRESSED) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/stopwatch_key_ctrl_key_debounce.sv
// key_debounce: synchronizer, debounce FSM, stability counter and press-pulse
// register for one active-low push button.
// Ports:
//   clk       : clock, rising edge
//   key_reset : synchronous active-low reset
//   key       : raw asynchronous key, 0 = pressed
//   pulse     : one-cycle strobe after each accepted press
//   state     : current debounce FSM state (debug and level decode)
module key_debounce
  import stopwatch_key_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TIME = DEBOUNCE_TIME_DEFAULT
) (
  input  logic       clk,
  input  logic       key_reset,
  input  logic       key,
  output logic       pulse,
  output key_state_t state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TIME - 1);

  logic [1:0]       sync;
  logic             key_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  key_state_t       state_next;
  logic             pulse_next;

  assign key_s = sync[1];

  always_ff @(posedge clk) begin
    if (!key_reset) begin
      sync  <= 2'b11;
      state <= RELEASED;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], key};
      state <= state_next;
      cnt   <= cnt_next;
      pulse <= pulse_next;
    end
  end

  // The first opposite sample enters the wait state with cnt=0, so a level
  // change is accepted on the DEBOUNCE_TIME-th consecutive opposite sample
  // seen while waiting; any agreeing sample abandons the wait.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    pulse_next = 1'b0;
    case (state)
      RELEASED: begin
        if (!key_s) state_next = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_next = RELEASED;
        end else if (cnt == CNT_LAST) begin
          state_next = PRESSED;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (key_s) state_next = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_next = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_next = RELEASED;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = RELEASED;
    endcase
  end

endmodule

// File: rtl/stopwatch_key_ctrl.sv
// stopwatch_key_ctrl: debounces the start/pause and display-freeze keys and
// keeps the run / display-refresh toggle states of the stopwatch.
// Ports:
//   clk              : 50 MHz clock, rising edge
//   key_reset        : synchronous active-low reset
//   key_start_pause  : raw start/pause key, 0 = pressed
//   key_display_stop : raw display-freeze key, 0 = pressed
//   start_pulse      : one-cycle strobe per accepted start/pause press
//   display_pulse    : one-cycle strobe per accepted display press
//   counter_work     : 1 = stopwatch is counting
//   display_work     : 1 = display follows the counter
//   led1, led2       : debounced key levels, 1 = held
module stopwatch_key_ctrl
  import stopwatch_key_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TIME = DEBOUNCE_TIME_DEFAULT
) (
  input  logic clk,
  input  logic key_reset,
  input  logic key_start_pause,
  input  logic key_display_stop,
  output logic start_pulse,
  output logic display_pulse,
  output logic counter_work,
  output logic display_work,
  output logic led1,
  output logic led2
);

  key_state_t start_state;
  key_state_t display_state;

  key_debounce #(.DEBOUNCE_TIME(DEBOUNCE_TIME)) u_start (
    .clk       (clk),
    .key_reset (key_reset),
    .key       (key_start_pause),
    .pulse     (start_pulse),
    .state     (start_state)
  );

  key_debounce #(.DEBOUNCE_TIME(DEBOUNCE_TIME)) u_display (
    .clk       (clk),
    .key_reset (key_reset),
    .key       (key_display_stop),
    .pulse     (display_pulse),
    .state     (display_state)
  );

  assign led1 = is_held(start_state);
  assign led2 = is_held(display_state);

  // Display refresh is on out of reset; counting is off.
  always_ff @(posedge clk) begin
    if (!key_reset) begin
      counter_work <= 1'b0;
      display_work <= 1'b1;
    end else begin
      if (start_pulse)   counter_work <= ~counter_work;
      if (display_pulse) display_work <= ~display_work;
    end
  end

endmodule

// File: doc/stopwatch_key_ctrl.md
STOPWATCH_KEY_CTRL -- requirements
Module: stopwatch_key_ctrl

Interface
REQ-001 Parameter DEBOUNCE_TIME, default 1000000, is the number of consecutive stable clk samples required to accept a level change (20 ms at 50 MHz); the legal range is 2..1048575.
REQ-002 clk  input  1  is the 50 MHz board clock; all logic is clocked on the rising edge.
REQ-003 key_reset  input  1  is the reset: synchronous, active-low.
REQ-004 key_start_pause  input  1  is the raw start/pause KEY, asynchronous, 0 = pressed.
REQ-005 key_display_stop  input  1  is the raw display-freeze KEY, asynchronous, 0 = pressed.
REQ-006 start_pulse  output  1  is a one-cycle strobe on each accepted start/pause press.
REQ-007 display_pulse  output  1  is a one-cycle strobe on each accepted display press.
REQ-008 counter_work  output  1  is the timing-run state: 1 = stopwatch counts.
REQ-009 display_work  output  1  is the display-refresh state: 1 = display tracks the counter.
REQ-010 led1  output  1  is the debounced start/pause key level, 1 = held.
REQ-011 led2  output  1  is the debounced display key level, 1 = held.

Function
REQ-012 Each raw key shall pass through a 2-flop synchronizer before any other use.
REQ-013 Each key shall have an independent debounce FSM with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT, plus a 20-bit stability counter.
REQ-014 RELEASED: a synchronized 0 shall move the FSM to PRESS_WAIT with the counter at 0.
REQ-015 PRESS_WAIT: a synchronized 0 shall increment the counter; a synchronized 1 shall return the FSM to RELEASED with the counter cleared; when the counter reaches DEBOUNCE_TIME-1 with a 0 sample, the FSM shall enter PRESSED and clear the counter.
REQ-016 PRESSED: a synchronized 1 shall move the FSM to RELEASE_WAIT with the counter at 0.
REQ-017 RELEASE_WAIT shall mirror PRESS_WAIT with polarity inverted, ending in RELEASED; a glitch back to 0 shall return the FSM to PRESSED.
REQ-018 The press pulse shall be registered and high exactly one cycle, in the cycle after the PRESS_WAIT->PRESSED transition; release produces no pulse.
REQ-019 Latency: for a key that goes low at the pin before edge N and stays low, the pulse shall be high in cycle N+DEBOUNCE_TIME+2, within +-1 cycle for synchronizer phase.
REQ-020 Holding a key for any duration shall produce exactly one pulse; auto-repeat is not performed.
REQ-021 counter_work shall toggle in the cycle after start_pulse is high.
REQ-022 display_work shall toggle in the cycle after display_pulse is high.
REQ-023 led1 and led2 shall be 1 in states PRESSED and RELEASE_WAIT, and 0 otherwise.
REQ-024 Simultaneous presses shall be processed independently, so both pulses and both toggles may occur in the same cycle.
REQ-025 Bounce shorter than DEBOUNCE_TIME cycles, on either edge, shall produce no pulse and no state change.
REQ-026 The counter shall never exceed DEBOUNCE_TIME-1 and shall not wrap.

Reset
REQ-027 When key_reset=0 at a rising clk edge, the module shall set: both FSMs to RELEASED, the counters to 0, the synchronizer flops to 1, start_pulse=0, display_pulse=0, counter_work=0, display_work=1, led1=0, led2=0.
REQ-028 Reset asserted mid-debounce shall abort the debounce with no pulse.
REQ-029 A key still held low when reset releases shall be debounced as a fresh press and produce one pulse.

Structure
REQ-030 DEBOUNCE_TIME and the four state encodings shall reside in a shared stopwatch constants package/include, used by the debounce sub-module and the stopwatch top.
REQ-031 The synchronizer, FSM, counter and pulse register shall form one sub-module, key_debounce, instantiated twice.
REQ-032 The toggle registers shall reside in stopwatch_key_ctrl.

Verification (bench overrides DEBOUNCE_TIME=4)
REQ-033 Scenario: key_start_pause is held at 0 for 20 cycles, then 1 -> start_pulse is high for exactly one cycle, at cycle 6+-1; counter_work goes 0->1; led1 is 1 from PRESSED until the release debounce completes.
REQ-034 Scenario: key_start_pause is pulsed low for 3 cycles, 3 times, with 2-cycle gaps -> no start_pulse and counter_work stays 0.
REQ-035 Scenario: both keys go low in the same cycle and are held for 10 cycles -> start_pulse and display_pulse assert in the same cycle; counter_work=1 and display_work=0.
REQ-036 Scenario: four separate clean presses of key_display_stop -> display_work takes the sequence 1,0,1,0,1 and exactly four pulses occur.
REQ-037 Scenario: key_reset=0 while in PRESS_WAIT (counter=2) -> no pulse; all outputs take reset values the next cycle; a held key yields one pulse after reset releases.
REQ-038 Scenario: key held for 1000 cycles with a 2-cycle high glitch at cycle 500 -> exactly one pulse, and led1 stays 1 through the glitch.
